// File: rtl/alu_exec_stage.sv
// Execute stage: a 2-entry input FIFO feeds the 4-bit ALU into a registered result with flags.
// Define ALU_SAT_EN to clamp overflowing ADD/SUB results to the signed limits.
module ALU (
  input  logic [3:0] ALU_In1,
  input  logic [3:0] ALU_In2,
  input  logic [1:0] ALU_Sel,
  output logic [3:0] ALU_Out,
  output logic       Error
);
  always_comb begin
    ALU_Out = 4'd0;
    Error   = 1'b0;
    unique case (ALU_Sel)
      2'b00: begin
        ALU_Out = ALU_In1 + ALU_In2;
        Error   = (ALU_In1[3] == ALU_In2[3]) &&
                  (ALU_Out[3] != ALU_In1[3]);
      end
      2'b01: begin
        ALU_Out = ALU_In1 - ALU_In2;
        Error   = (ALU_In1[3] != ALU_In2[3]) &&
                  (ALU_Out[3] != ALU_In1[3]);
      end
      2'b10: ALU_Out = ~(ALU_In1 & ALU_In2);
      2'b11: ALU_Out = ALU_In1 ^ ALU_In2;
      default: ALU_Out = 4'd0;
    endcase
  end
endmodule

module alu_exec_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_result,
  output logic             out_ovfl,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic [CNT_W-1:0] ovfl_count
);
  logic [3:0]       r_a [2];
  logic [3:0]       r_b [2];
  logic [1:0]       r_op [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             r_valid;
  logic [3:0]       r_result;
  logic             r_ovfl;
  logic             r_z;
  logic             r_n;
  logic             r_v;
  logic [CNT_W-1:0] r_cnt;

  logic       w_push;
  logic       w_pop;
  logic [3:0] w_alu_out;
  logic       w_alu_err;
  logic [3:0] w_res;
  logic [1:0] w_hop;

  assign in_ready = !rst && (r_count < 2'd2);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_count != 2'd0) && (!r_valid || out_ready);
  assign w_hop    = r_op[r_rptr];

  ALU u_alu (
    .ALU_In1 (r_a[r_rptr]),
    .ALU_In2 (r_b[r_rptr]),
    .ALU_Sel (w_hop),
    .ALU_Out (w_alu_out),
    .Error   (w_alu_err)
  );

`ifdef ALU_SAT_EN
  // Clamp toward the sign of operand A, which is the sign the true result has.
  assign w_res = (w_alu_err && !w_hop[1]) ?
                 (r_a[r_rptr][3] ? 4'b1000 : 4'b0111) :
                 w_alu_out;
`else
  assign w_res = w_alu_out;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_a[r_wptr]  <= in_a;
      r_b[r_wptr]  <= in_b;
      r_op[r_wptr] <= in_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
      r_valid  <= 1'b0;
      r_result <= 4'd0;
      r_ovfl   <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      if (w_push && !w_pop)      r_count <= r_count + 2'd1;
      else if (!w_push && w_pop) r_count <= r_count - 2'd1;
      if (w_pop) begin
        r_valid  <= 1'b1;
        r_result <= w_res;
        r_ovfl   <= w_alu_err;
        r_z      <= (w_res == 4'd0);
        r_n      <= w_res[3];
        if (!w_hop[1]) r_v <= w_alu_err;
        if (w_alu_err && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_ovfl   = r_ovfl;
  assign flag_z     = r_z;
  assign flag_n     = r_n;
  assign flag_v     = r_v;
  assign ovfl_count = r_cnt;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: randomized and directed packets vs a behavioural model.
module tb_alu_exec_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_ovfl;
  logic       flag_z;
  logic       flag_n;
  logic       flag_v;
  logic [7:0] ovfl_count;

  int checks = 0;
  int errors = 0;

  logic rand_rdy = 1'b0;
  logic rnd_bit  = 1'b1;
  logic rdy_main = 1'b1;
  assign out_ready = rand_rdy ? rnd_bit : rdy_main;

  typedef struct packed {
    logic [3:0] res;
    logic       ovfl;
    logic       z;
    logic       n;
    logic       v;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  logic m_v;
  int   m_cnt;

  alu_exec_stage #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovfl   (out_ovfl),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_v     (flag_v),
    .ovfl_count (ovfl_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) rnd_bit = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Model: results leave in acceptance order, so flags/counter evolve at push time.
  task automatic model_push(input logic [3:0] a, input logic [3:0] b,
                            input logic [1:0] op);
    int   sa, sb, s;
    logic ov;
    logic [3:0] r;
    exp_t e;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    ov = 1'b0;
    case (op)
      2'd0: s = sa + sb;
      2'd1: s = sa - sb;
      2'd2: s = int'(~(a & b));
      default: s = int'(a ^ b);
    endcase
    if (op < 2) ov = (s > 7) || (s < -8);
    r = 4'(s);
`ifdef ALU_SAT_EN
    if (ov) r = (s > 7) ? 4'b0111 : 4'b1000;
`endif
    if (op < 2) m_v = ov;
    if (ov && m_cnt < 255) m_cnt++;
    e.res  = r;
    e.ovfl = ov;
    e.z    = (r == 4'd0);
    e.n    = r[3];
    e.v    = m_v;
    e.cnt  = 8'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] op);
    int t = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    @(negedge clk);
    while (!in_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready=0 for %0d cycles, expected 1", t);
    end else begin
      model_push(a, b, op);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: pop on each completed output handshake, and check held results stay stable.
  logic       held = 1'b0;
  logic [3:0] h_res;
  logic       h_ovfl;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else if (out_valid && !out_ready) begin
      if (held) begin
        chk("hold_result", int'(out_result), int'(h_res));
        chk("hold_ovfl", int'(out_ovfl), int'(h_ovfl));
      end
      held   = 1'b1;
      h_res  = out_result;
      h_ovfl = out_ovfl;
    end else if (out_valid && out_ready) begin
      held = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: result=%0h with empty scoreboard", out_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", int'(out_result), int'(e.res));
        chk("ovfl", int'(out_ovfl), int'(e.ovfl));
        chk("flag_z", int'(flag_z), int'(e.z));
        chk("flag_n", int'(flag_n), int'(e.n));
        chk("flag_v", int'(flag_v), int'(e.v));
        chk("ovfl_count", int'(ovfl_count), int'(e.cnt));
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_result"}, int'(out_result), 0);
    chk({tag, "_flags"}, int'({flag_z, flag_n, flag_v, out_ovfl}), 0);
    chk({tag, "_ovfl_count"}, int'(ovfl_count), 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = 4'd0;
    in_b = 4'd0;
    in_op = 2'd0;
    m_v = 1'b0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    check_reset_state("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Latency: empty stage, accepted at edge N, visible after edge N+1.
    push(4'd3, 4'd4, 2'd0);
    @(negedge clk);
    chk("latency_n", int'(out_valid), 0);
    @(negedge clk);
    chk("latency_n1", int'(out_valid), 1);
    @(posedge clk);
    #1;

    push(4'd7, 4'd1, 2'd0);
    push(4'd5, 4'd5, 2'd1);
    push(4'd7, 4'd1, 2'd0);
    push(4'hF, 4'hF, 2'd2);
    push(4'h8, 4'd1, 2'd1);
    push(4'hA, 4'h5, 2'd3);
    drain();
    chk("v_held_after_xor", int'(flag_v), 1);

    // Backpressure: capacity of three, fourth held upstream.
    rdy_main = 1'b0;
    push(4'd1, 4'd1, 2'd0);
    push(4'd2, 4'd2, 2'd0);
    push(4'd3, 4'd3, 2'd0);
    @(negedge clk);
    chk("full_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    fork
      push(4'd4, 4'd4, 2'd0);
      begin
        repeat (6) @(posedge clk);
        #1;
        rdy_main = 1'b1;
      end
    join
    drain();

    // Randomized traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      push(4'($urandom), 4'($urandom), 2'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    drain();

    // Counter saturation.
    for (int i = 0; i < 300; i++) push(4'd7, 4'd1, 2'd0);
    drain();
    chk("sat_count", int'(ovfl_count), 255);

    // Reset with three packets pending drops everything.
    rdy_main = 1'b0;
    push(4'd7, 4'd1, 2'd0);
    push(4'd2, 4'd3, 2'd0);
    push(4'd6, 4'd1, 2'd1);
    @(negedge clk);
    chk("pre_rst_full", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    m_v = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_main = 1'b1;
    @(negedge clk);
    check_reset_state("mid_rst");
    chk("mid_rst_in_ready_after", int'(in_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    push(4'd2, 4'd2, 2'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute stage wrapped around the team's combinational 4-bit ALU (module `ALU`: ADD/SUB/NAND/XOR with a signed-overflow `Error` output). The stage accepts operand/opcode packets over a valid/ready handshake and buffers them in a 2-entry input FIFO. It drives the FIFO head through one `ALU` instance and registers the result into an output register with its own valid/ready handshake. It also maintains a condition-flag register (Z, V, N) and a saturating overflow event counter for the downstream writeback/branch logic.

## Interface
- `CNT_W`, 8, width of overflow event counter
- `clk` input 1: single clock; all state updates on rising edge
- `rst` input 1: synchronous, active-high reset
- `in_valid` input 1: upstream packet valid
- `in_ready` output 1: stage can accept a packet this cycle
- `in_a` input 4: operand A (ALU_In1)
- `in_b` input 4: operand B (ALU_In2)
- `in_op` input 2: opcode; 00 ADD, 01 SUB, 10 NAND, 11 XOR
- `out_valid` output 1: output register holds a result
- `out_ready` input 1: downstream accepts the result
- `out_result` output 4: registered ALU result
- `out_ovfl` output 1: registered signed overflow of that result
- `flag_z` output 1: result == 0
- `flag_n` output 1: result[3]
- `flag_v` output 1: last ADD/SUB overflow
- `ovfl_count` output CNT_W: number of overflowing ops loaded, saturating

## Operation
- Push: `in_valid && in_ready` writes {a,b,op} at the FIFO tail.
- `in_ready = !rst && (fifo_count < 2)`. It is derived from registered count only; there is no same-cycle pass-through when full.
- Load: when `fifo_count != 0 && (!out_valid || out_ready)`, the head is popped. At the same edge, its ALU result and overflow are written to `out_result` and `out_ovfl`, and `out_valid` is set.
- If out_ready is high with no pop, `out_valid` clears. Unaccepted results are held stable (`out_result` and `out_ovfl` unchanged while `out_valid && !out_ready`).
- Simultaneous push and pop: `fifo_count` is unchanged and order is preserved. Push when count==2 is impossible because in_ready is 0.
- FIFO pointers are 1-bit and wrap modulo 2.
- Flags update only on a load edge:
  - Z and N always update from the loaded result.
  - V updates only for ADD/SUB (op 0x). It holds its value for NAND/XOR.
- `ovfl_count` increments on a load edge when the loaded overflow is 1. It holds at 2^CNT_W−1.
- Arithmetic is 4-bit two's complement; carry-out is discarded. Overflow is defined as:
  - ADD: A[3]==B[3] and R[3]!=A[3]
  - SUB: A[3]!=B[3] and R[3]!=A[3]
  - NAND/XOR: overflow is always 0.

## Timing
- Latency: a packet accepted at edge N with an empty stage appears with `out_valid=1` after edge N+1, i.e. 2 cycles from in_valid assertion.
- Throughput: 1 packet/cycle while `out_ready=1`.
- Capacity: 3 packets in flight (2 FIFO + 1 output register).
- Reset (synchronous, checked at every edge, takes priority over all other activity):
  - `fifo_count=0`, pointers 0, `out_valid=0`, `out_result=0`, `out_ovfl=0`, `flag_z=0`, `flag_n=0`, `flag_v=0`, `ovfl_count=0`.
  - `in_ready=0` while `rst=1`.
  - Reset mid-operation drops all buffered packets; no partial update occurs.

## Configuration
- `ALU_SAT_EN` defined: ADD/SUB results that overflow are clamped before registration.
  - The result clamps to 4'b0111 if `in_a[3]==0`, else 4'b1000.
  - `out_ovfl`, V and `ovfl_count` still report the overflow.
  - Z and N derive from the clamped value.
- Not defined: the wrapped ALU result is registered unchanged.

## Test plan
- ADD a=3,b=4, out_ready=1 → 2 cycles later out_result=0111, out_ovfl=0, Z=0, N=0, V=0, ovfl_count=0.
- ADD a=7,b=1 → out_result=1000 (0111 with ALU_SAT_EN), out_ovfl=1, V=1, ovfl_count=1. N=1 without ALU_SAT_EN; N=0 with ALU_SAT_EN.
- SUB a=5,b=5 → 0000, Z=1, V=0. Then ADD 7+1 sets V=1. Then NAND a=F,b=F → 0000, Z=1, V stays 1.
- out_ready=0, push 4 packets back-to-back:
  - in_ready drops after the third acceptance; the fourth is held by upstream.
  - The output register holds packet 1 stable.
  - After out_ready=1, results emerge in order 1,2,3,4 on consecutive cycles.
- 300 consecutive ADD 7+1 → ovfl_count saturates at 255 and stays there.
- Fill stage (3 packets pending, out_ready=0), assert rst for 1 cycle → next cycle out_valid=0, all flags 0, ovfl_count=0, in_ready=1. No dropped packet ever appears on the output.
